// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a WIDTH-bit parallel-load / shift / rotate register.
// Define SHIFT_SEQ_CTRL_ABORT_EN to add the abort input and aborted flag.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             sin,
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic [WIDTH-1:0] dout,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_e;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SHR  = 2'b10;
   localparam logic [1:0] OP_ROL  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] shift_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic             done_q;
   logic             abort_hit;

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
   logic aborted_q;
   assign abort_hit = abort;
   assign aborted   = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      shift_d = dout_q;
      case (op_q)
         OP_SHL:  shift_d = {dout_q[WIDTH-2:0], sin};
         OP_SHR:  shift_d = {sin, dout_q[WIDTH-1:1]};
         OP_ROL:  shift_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
         default: shift_d = dout_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         dout_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         op_q      <= OP_LOAD;
         done_q    <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
         aborted_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  data_q <= cmd_data;
                  cnt_q  <= cmd_amt;
                  if (cmd_op == OP_LOAD) begin
                     state_q <= S_LOAD;
                  end else if (cmd_amt == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                  end
               end
            end
            S_LOAD: begin
               dout_q  <= data_q;
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_SHIFT: begin
               if (abort_hit) begin
                  // Abort holds dout: the edge that sees abort never shifts
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
                  aborted_q <= 1'b1;
`endif
               end else begin
                  dout_q <= shift_d;
                  cnt_q  <= cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign dout      = dout_q;

   always_comb begin
      sout = 1'b0;
      if (state_q != S_IDLE) begin
         sout = (op_q == OP_SHR) ? dout_q[0] : dout_q[WIDTH-1];
      end
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit parallel/serial shift register.
- Accepts one command per valid/ready handshake: parallel load, shift left, shift right or rotate left.
- Shift commands run for a programmed number of cycles, then pulse done.
- Sits between a host/control FSM and the shift-register datapath; owns the register contents (dout).

Parameters:
- WIDTH, 4, register width in bits (>=2)
- CNT_W, 3, width of the shift-amount field; max amount 2^CNT_W-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserts on negedge, low = in reset)
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_op  input  2  00 LOAD, 01 SHL, 10 SHR, 11 ROL
- cmd_amt  input  CNT_W  shift count (ignored for LOAD)
- cmd_data  input  WIDTH  parallel load value (used for LOAD only)
- sin  input  1  serial input, sampled on every shift cycle of SHL/SHR
- dout  output  WIDTH  register contents (registered)
- sout  output  1  serial output, combinational: dout[WIDTH-1] for SHL/ROL, dout[0] for SHR, 0 in IDLE
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, high in DONE state

Behaviour:
- Reset (rst low, async):
  - state=IDLE, dout=0, counter=0, latched op/amt/data=0, done=0, busy=0.
  - cmd_ready reads 1 (IDLE), but no command is accepted while rst is low.
- Accept: cmd_valid && cmd_ready at a rising edge. Latch op, amt and data, then go:
  - LOAD state if op==00
  - DONE state if shift op with amt==0 (dout unchanged)
  - otherwise SHIFT state, with counter=amt
- LOAD: at the next edge dout<=latched data; go to DONE.
- SHIFT: one bit per edge; counter decrements. When counter==1 at an edge, that final shift occurs and the state goes to DONE.
  - SHL: dout<={dout[WIDTH-2:0], sin}
  - SHR: dout<={sin, dout[WIDTH-1:1]}
  - ROL: dout<={dout[WIDTH-2:0], dout[WIDTH-1]}; sin ignored
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency, with acceptance at edge E0:
  - LOAD: dout updates at E1; done high E1–E2; cmd_ready high again after E2.
  - Shift by N>=1: shifts at E1..EN; done high EN–E(N+1); IDLE after E(N+1).
  - Shift by 0: done high E0–E1.
- No back-to-back acceptance. The minimum command period is 3 cycles (LOAD) or N+2 cycles (shift).
- cmd_* inputs are don't-care outside the accept edge; only latched values are used.
- Reset mid-operation: immediate abort to reset values; no done pulse is generated.
- Amounts >= WIDTH are legal. For SHL/SHR the register is then fully replaced by sampled sin bits. ROL by WIDTH returns the original value.

Optional Feature:
- Macro: SHIFT_SEQ_CTRL_ABORT_EN
- Defined:
  - Adds input abort (1b) and output aborted (1b).
  - abort high at an edge while in SHIFT: no shift on that edge; go to DONE with dout held.
  - aborted=1 alongside done for that single DONE cycle; aborted=0 at all other times, including reset.
  - abort is ignored in IDLE, LOAD and DONE.
- Undefined: neither port exists; SHIFT always runs to completion.

Test Plan:
- Reset then LOAD data=4'b1011 -> dout=0 until E1, dout=1011 at E1, done pulse 1 cycle, cmd_ready=0 for 2 cycles, then 1.
- LOAD 1011, then SHL amt=2 with sin=1,0 -> dout 0111 after E1, 1110 after E2; sout=1 then 0; done after E2.
- LOAD 1000, SHR amt=3 with sin=0 -> dout 0100, 0010, 0001; busy high 4 cycles; done once.
- LOAD 1001, ROL amt=4 -> dout returns to 1001; ROL amt=0 -> done immediately next cycle, dout unchanged.
- SHL amt=7, drive rst low after 2 shifts -> dout=0, busy=0, done never pulses; after release, a new LOAD is accepted normally.
- (ABORT_EN) LOAD 0001, SHL amt=5 sin=0, abort at 3rd shift edge -> dout=0100, done and aborted both high for one cycle, then IDLE.
